id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage that turns a fetched RV32I instruction and its register-file read data into the operand and control set consumed by the ALU (rdata1, rdata2, imm, alu_src, alu_ctrl), plus writeback/memory/branch side controls. It is the producing end of the ALU's control interface. It sits between instruction fetch/register read and the execute stage, holding one instruction in a registered slot under a valid/ready handshake with flush support.

---
 rtl/id_ex_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode-to-execute pipeline slot.
// Decodes the incoming instruction combinationally and captures the ALU
// operand/control set in a single registered slot. The slot uses a valid/ready
// handshake and can be flushed. All outputs read zero while the slot is empty.
// Optional feature macro: ID_ILLEGAL_TRAP_EN adds the `illegal` output.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2,
    output logic [XLEN-1:0]   imm,
    output logic              alu_src,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [4:0]        rd,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              is_branch,
    output logic              is_jal,
    output logic              is_jalr,
    output logic [2:0]        mem_funct3,
    output logic [XLEN-1:0]   pc_out
`ifdef ID_ILLEGAL_TRAP_EN
    ,
    output logic              illegal
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [CTRL_W-1:0] ALUCTRL_ADD  = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] ALUCTRL_SUB  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] ALUCTRL_SLT  = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] ALUCTRL_SLTU = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] ALUCTRL_AND  = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] ALUCTRL_OR   = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] ALUCTRL_XOR  = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] ALUCTRL_SLL  = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] ALUCTRL_SRL  = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] ALUCTRL_SRA  = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] ALUCTRL_BEQ  = CTRL_W'(10);
    localparam logic [CTRL_W-1:0] ALUCTRL_BNE  = CTRL_W'(11);
    localparam logic [CTRL_W-1:0] ALUCTRL_BLT  = CTRL_W'(12);
    localparam logic [CTRL_W-1:0] ALUCTRL_BGE  = CTRL_W'(13);
    localparam logic [CTRL_W-1:0] ALUCTRL_BLTU = CTRL_W'(14);
    localparam logic [CTRL_W-1:0] ALUCTRL_BGEU = CTRL_W'(15);

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_f;
    logic       f7_zero;
    logic       f7_alt;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign rd_f    = instr[11:7];
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    // Immediates
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_sh = {27'b0, instr[24:20]};

    // Shared funct3 -> ALU op map for OP and OP-IMM; alt selects SUB/SRA
    function automatic logic [CTRL_W-1:0] arith_op(input logic [2:0] f3, input logic alt);
        logic [CTRL_W-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALUCTRL_SUB : ALUCTRL_ADD;
            3'b001:  op = ALUCTRL_SLL;
            3'b010:  op = ALUCTRL_SLT;
            3'b011:  op = ALUCTRL_SLTU;
            3'b100:  op = ALUCTRL_XOR;
            3'b101:  op = alt ? ALUCTRL_SRA : ALUCTRL_SRL;
            3'b110:  op = ALUCTRL_OR;
            default: op = ALUCTRL_AND;
        endcase
        return op;
    endfunction

    // Next-slot contents
    logic [XLEN-1:0]   rdata1_d, imm_d;
    logic              alu_src_d;
    logic [CTRL_W-1:0] alu_ctrl_d;
    logic [4:0]        rd_d;
    logic              reg_write_d, mem_read_d, mem_write_d;
    logic              is_branch_d, is_jal_d, is_jalr_d;
    logic [2:0]        mem_funct3_d;
    logic              legal_d;

    // Slot registers
    logic              out_valid_q;
    logic [XLEN-1:0]   rdata1_q, rdata2_q, imm_q, pc_q;
    logic              alu_src_q;
    logic [CTRL_W-1:0] alu_ctrl_q;
    logic [4:0]        rd_q;
    logic              reg_write_q, mem_read_q, mem_write_q;
    logic              is_branch_q, is_jal_q, is_jalr_q;
    logic [2:0]        mem_funct3_q;

    logic load;

    assign in_ready = !out_valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // Combinational decode of the incoming instruction
    always_comb begin
        rdata1_d     = rs1_val;
        imm_d        = '0;
        alu_src_d    = 1'b0;
        alu_ctrl_d   = ALUCTRL_ADD;
        rd_d         = '0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        is_branch_d  = 1'b0;
        is_jal_d     = 1'b0;
        is_jalr_d    = 1'b0;
        mem_funct3_d = '0;
        legal_d      = 1'b0;

        case (opcode)
            OPC_OP: begin
                rd_d        = rd_f;
                reg_write_d = 1'b1;
                if (funct3 == 3'b000 || funct3 == 3'b101) begin
                    legal_d    = f7_zero || f7_alt;
                    alu_ctrl_d = arith_op(funct3, f7_alt);
                end else begin
                    legal_d    = f7_zero;
                    alu_ctrl_d = arith_op(funct3, 1'b0);
                end
            end
            OPC_OPIMM: begin
                rd_d        = rd_f;
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                if (funct3 == 3'b001) begin
                    legal_d    = f7_zero;
                    imm_d      = imm_sh;
                    alu_ctrl_d = ALUCTRL_SLL;
                end else if (funct3 == 3'b101) begin
                    legal_d    = f7_zero || f7_alt;
                    imm_d      = imm_sh;
                    alu_ctrl_d = arith_op(funct3, instr[30]);
                end else begin
                    legal_d    = 1'b1;
                    imm_d      = imm_i;
                    alu_ctrl_d = arith_op(funct3, 1'b0);
                end
            end
            OPC_LOAD: begin
                legal_d      = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                               (funct3 == 3'b100) || (funct3 == 3'b101);
                rd_d         = rd_f;
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                imm_d        = imm_i;
                mem_read_d   = 1'b1;
                mem_funct3_d = funct3;
            end
            OPC_STORE: begin
                legal_d      = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
                alu_src_d    = 1'b1;
                imm_d        = imm_s;
                mem_write_d  = 1'b1;
                mem_funct3_d = funct3;
            end
            OPC_BRANCH: begin
                legal_d     = (funct3 != 3'b010) && (funct3 != 3'b011);
                imm_d       = imm_b;
                is_branch_d = 1'b1;
                case (funct3)
                    3'b000:  alu_ctrl_d = ALUCTRL_BEQ;
                    3'b001:  alu_ctrl_d = ALUCTRL_BNE;
                    3'b100:  alu_ctrl_d = ALUCTRL_BLT;
                    3'b101:  alu_ctrl_d = ALUCTRL_BGE;
                    3'b110:  alu_ctrl_d = ALUCTRL_BLTU;
                    default: alu_ctrl_d = ALUCTRL_BGEU;
                endcase
            end
            OPC_LUI: begin
                legal_d     = 1'b1;
                rdata1_d    = '0;
                alu_src_d   = 1'b1;
                imm_d       = imm_u;
                rd_d        = rd_f;
                reg_write_d = 1'b1;
            end
            OPC_AUIPC: begin
                legal_d     = 1'b1;
                rdata1_d    = pc;
                alu_src_d   = 1'b1;
                imm_d       = imm_u;
                rd_d        = rd_f;
                reg_write_d = 1'b1;
            end
            OPC_JAL: begin
                legal_d     = 1'b1;
                rdata1_d    = pc;
                alu_src_d   = 1'b1;
                imm_d       = imm_j;
                is_jal_d    = 1'b1;
                rd_d        = rd_f;
                reg_write_d = 1'b1;
            end
            OPC_JALR: begin
                legal_d     = (funct3 == 3'b000);
                alu_src_d   = 1'b1;
                imm_d       = imm_i;
                is_jalr_d   = 1'b1;
                rd_d        = rd_f;
                reg_write_d = 1'b1;
            end
            default: legal_d = 1'b0;
        endcase

        // Unknown encodings collapse to a no-op ADD with no side effects
        if (!legal_d) begin
            rdata1_d     = rs1_val;
            imm_d        = '0;
            alu_src_d    = 1'b0;
            alu_ctrl_d   = ALUCTRL_ADD;
            rd_d         = '0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            is_branch_d  = 1'b0;
            is_jal_d     = 1'b0;
            is_jalr_d    = 1'b0;
            mem_funct3_d = '0;
        end

        if (rd_d == 5'd0) begin
            reg_write_d = 1'b0;
        end
    end

    // Slot register: load on handshake, clear on flush or when drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            rdata1_q     <= '0;
            rdata2_q     <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            alu_src_q    <= 1'b0;
            alu_ctrl_q   <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            is_branch_q  <= 1'b0;
            is_jal_q     <= 1'b0;
            is_jalr_q    <= 1'b0;
            mem_funct3_q <= '0;
        end else if (load) begin
            out_valid_q  <= 1'b1;
            rdata1_q     <= rdata1_d;
            rdata2_q     <= rs2_val;
            imm_q        <= imm_d;
            pc_q         <= pc;
            alu_src_q    <= alu_src_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            is_branch_q  <= is_branch_d;
            is_jal_q     <= is_jal_d;
            is_jalr_q    <= is_jalr_d;
            mem_funct3_q <= mem_funct3_d;
        end else if (flush || (out_valid_q && out_ready)) begin
            // Emptying the slot also zeroes the payload so outputs read 0 when idle
            out_valid_q  <= 1'b0;
            rdata1_q     <= '0;
            rdata2_q     <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            alu_src_q    <= 1'b0;
            alu_ctrl_q   <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            is_branch_q  <= 1'b0;
            is_jal_q     <= 1'b0;
            is_jalr_q    <= 1'b0;
            mem_funct3_q <= '0;
        end
    end

`ifdef ID_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Illegal flag tracks the slot exactly like the other strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (load) begin
            illegal_q <= !legal_d;
        end else if (flush || (out_valid_q && out_ready)) begin
            illegal_q <= 1'b0;
        end
    end

    assign illegal = illegal_q;
`endif

    assign out_valid  = out_valid_q;
    assign rdata1     = rdata1_q;
    assign rdata2     = rdata2_q;
    assign imm        = imm_q;
    assign pc_out     = pc_q;
    assign alu_src    = alu_src_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rd         = rd_q;
    assign reg_write  = reg_write_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign is_branch  = is_branch_q;
    assign is_jal     = is_jal_q;
    assign is_jalr    = is_jalr_q;
    assign mem_funct3 = mem_funct3_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected slot contents are queued when an
// instruction is driven and compared when the stage presents it.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] rdata1, rdata2, imm, pc_out;
    logic        alu_src;
    logic [4:0]  alu_ctrl;
    logic [4:0]  rd;
    logic        reg_write, mem_read, mem_write, is_branch, is_jal, is_jalr;
    logic [2:0]  mem_funct3;
`ifdef ID_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [31:0] pc_out;
        logic        alu_src;
        logic [4:0]  alu_ctrl;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic [2:0]  mem_funct3;
        logic        illegal;
    } exp_t;

    exp_t sb_q[$];

    id_ex_stage #(.XLEN(32), .CTRL_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .rdata1(rdata1), .rdata2(rdata2), .imm(imm),
        .alu_src(alu_src), .alu_ctrl(alu_ctrl), .rd(rd),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .mem_funct3(mem_funct3), .pc_out(pc_out)
`ifdef ID_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] im, input logic [31:0] p,
                                input logic src, input logic [4:0] ctrl, input logic [4:0] rdv,
                                input logic rw, input logic mr, input logic mw,
                                input logic br, input logic jl, input logic jr,
                                input logic [2:0] f3, input logic ill);
        exp_t e;
        e.rdata1 = r1; e.rdata2 = r2; e.imm = im; e.pc_out = p;
        e.alu_src = src; e.alu_ctrl = ctrl; e.rd = rdv;
        e.reg_write = rw; e.mem_read = mr; e.mem_write = mw;
        e.is_branch = br; e.is_jal = jl; e.is_jalr = jr;
        e.mem_funct3 = f3;
`ifdef ID_ILLEGAL_TRAP_EN
        e.illegal = ill;
`else
        e.illegal = 1'b0;
        if (ill) e.illegal = 1'b0;
`endif
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t s;
        s.rdata1 = rdata1; s.rdata2 = rdata2; s.imm = imm; s.pc_out = pc_out;
        s.alu_src = alu_src; s.alu_ctrl = alu_ctrl; s.rd = rd;
        s.reg_write = reg_write; s.mem_read = mem_read; s.mem_write = mem_write;
        s.is_branch = is_branch; s.is_jal = is_jal; s.is_jalr = is_jalr;
        s.mem_funct3 = mem_funct3;
`ifdef ID_ILLEGAL_TRAP_EN
        s.illegal = illegal;
`else
        s.illegal = 1'b0;
`endif
        return s;
    endfunction

    // Present one instruction on the input side and queue its expected slot
    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
        in_valid = 1'b1; instr = i; pc = p; rs1_val = r1; rs2_val = r2;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t got;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        got = sample();
        checks++;
        if (out_valid !== 1'b0 || got !== '0) begin
            failures++;
            $display("FAIL reset_state out_valid=%0b got=%h required out_valid=0 all zero", out_valid, got);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b required=1", in_ready);
        end
    endtask

    // Single instruction: wait (bounded) for it and compare with the queue head
    task automatic test_single(input string name, input logic [31:0] i, input logic [31:0] p,
                               input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
        exp_t got, want;
        int c;
        @(negedge clk);
        out_ready = 1'b1;
        drive(i, p, r1, r2, e);
        @(negedge clk);
        in_valid = 1'b0;
        c = 0;
        while (!out_valid && c < 5) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!out_valid || sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s_timeout out_valid=%0b required=1", name, out_valid);
            sb_q.delete();
        end else begin
            got = sample();
            want = sb_q.pop_front();
            if (got !== want || c != 0) begin
                failures++;
                $display("FAIL %s got=%h required=%h latency_extra=%0d", name, got, want, c);
            end
        end
    endtask

    task automatic test_alu_ops();
        test_single("addi", 32'hFFB10093, 32'h100, 32'd10, 32'h55,
                    mk(32'd10, 32'h55, 32'hFFFFFFFB, 32'h100, 1, 5'd0, 5'd1, 1, 0, 0, 0, 0, 0, 3'd0, 0));
        test_single("sub", 32'h402081B3, 32'h104, 32'd20, 32'd7,
                    mk(32'd20, 32'd7, 32'd0, 32'h104, 0, 5'd1, 5'd3, 1, 0, 0, 0, 0, 0, 3'd0, 0));
        test_single("slti", 32'h00512093, 32'h414, 32'd7, 32'd0,
                    mk(32'd7, 32'd0, 32'd5, 32'h414, 1, 5'd2, 5'd1, 1, 0, 0, 0, 0, 0, 3'd0, 0));
        test_single("add_x0", 32'h00208033, 32'h408, 32'd3, 32'd4,
                    mk(32'd3, 32'd4, 32'd0, 32'h408, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0));
    endtask

    task automatic test_branch();
        test_single("beq", 32'h00208463, 32'h200, 32'd5, 32'd5,
                    mk(32'd5, 32'd5, 32'd8, 32'h200, 0, 5'd10, 5'd0, 0, 0, 0, 1, 0, 0, 3'd0, 0));
    endtask

    task automatic test_illegal();
        test_single("zero_instr", 32'h00000000, 32'h40C, 32'h11, 32'h22,
                    mk(32'h11, 32'h22, 32'd0, 32'h40C, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 3'd0, 1));
        test_single("bad_funct7", 32'h022081B3, 32'h410, 32'd2, 32'd3,
                    mk(32'd2, 32'd3, 32'd0, 32'h410, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 3'd0, 1));
    endtask

    task automatic test_stall();
        exp_t got, want;
        @(negedge clk);
        out_ready = 1'b1;
        drive(32'h40335293, 32'h108, 32'hF0000000, 32'd1,
              mk(32'hF0000000, 32'd1, 32'd3, 32'h108, 1, 5'd9, 5'd5, 1, 0, 0, 0, 0, 0, 3'd0, 0));
        @(negedge clk);
        // A second instruction waits at the input while the slot is stalled
        out_ready = 1'b0;
        drive(32'hFFB10093, 32'h10C, 32'd10, 32'd0,
              mk(32'd10, 32'd0, 32'hFFFFFFFB, 32'h10C, 1, 5'd0, 5'd1, 1, 0, 0, 0, 0, 0, 3'd0, 0));
        for (int k = 0; k < 4; k++) begin
            #1;
            got = sample();
            want = sb_q[0];
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== want) begin
                failures++;
                $display("FAIL stall_hold_%0d out_valid=%0b in_ready=%0b got=%h required=%h valid=1 ready=0",
                         k, out_valid, in_ready, got, want);
            end
            if (k < 3) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        void'(sb_q.pop_front());
        got = sample();
        want = sb_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || got !== want) begin
            failures++;
            $display("FAIL stall_release out_valid=%0b got=%h required=%h", out_valid, got, want);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        exp_t got;
        int seen;
        @(negedge clk);
        out_ready = 1'b1;
        drive(32'h402081B3, 32'h500, 32'd1, 32'd2,
              mk(32'd1, 32'd2, 32'd0, 32'h500, 0, 5'd1, 5'd3, 1, 0, 0, 0, 0, 0, 3'd0, 0));
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_preload out_valid=%0b required=1", out_valid);
        end
        // Held instruction and the one arriving with flush are both discarded
        out_ready = 1'b0;
        flush = 1'b1;
        in_valid = 1'b1; instr = 32'h12345237; pc = 32'h504;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sb_q.delete();
        got = sample();
        checks++;
        if (out_valid !== 1'b0 || got !== '0) begin
            failures++;
            $display("FAIL flush_clear out_valid=%0b got=%h required out_valid=0 all zero", out_valid, got);
        end
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL flush_dropped valid_cycles=%0d required=0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vi[8], vp[8], v1[8], v2[8];
        exp_t        ve[8];
        exp_t        got, want;
        int          popped;
        vi[0] = 32'h00C12383; vp[0] = 32'h110; v1[0] = 32'h1000; v2[0] = 32'h0;
        ve[0] = mk(32'h1000, 32'h0, 32'd12, 32'h110, 1, 5'd0, 5'd7, 1, 1, 0, 0, 0, 0, 3'd2, 0);
        vi[1] = 32'hFE512E23; vp[1] = 32'h114; v1[1] = 32'h1000; v2[1] = 32'hABCD;
        ve[1] = mk(32'h1000, 32'hABCD, 32'hFFFFFFFC, 32'h114, 1, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 3'd2, 0);
        vi[2] = 32'h12345237; vp[2] = 32'h118; v1[2] = 32'h99; v2[2] = 32'h0;
        ve[2] = mk(32'h0, 32'h0, 32'h12345000, 32'h118, 1, 5'd0, 5'd4, 1, 0, 0, 0, 0, 0, 3'd0, 0);
        vi[3] = 32'h00001217; vp[3] = 32'h300; v1[3] = 32'h99; v2[3] = 32'h0;
        ve[3] = mk(32'h300, 32'h0, 32'h1000, 32'h300, 1, 5'd0, 5'd4, 1, 0, 0, 0, 0, 0, 3'd0, 0);
        vi[4] = 32'h010000EF; vp[4] = 32'h400; v1[4] = 32'd7; v2[4] = 32'd8;
        ve[4] = mk(32'h400, 32'd8, 32'd16, 32'h400, 1, 5'd0, 5'd1, 1, 0, 0, 0, 1, 0, 3'd0, 0);
        vi[5] = 32'h00008067; vp[5] = 32'h404; v1[5] = 32'h500; v2[5] = 32'h0;
        ve[5] = mk(32'h500, 32'h0, 32'd0, 32'h404, 1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 3'd0, 0);
        vi[6] = 32'h40335293; vp[6] = 32'h408; v1[6] = 32'h80; v2[6] = 32'h3;
        ve[6] = mk(32'h80, 32'h3, 32'd3, 32'h408, 1, 5'd9, 5'd5, 1, 0, 0, 0, 0, 0, 3'd0, 0);
        vi[7] = 32'h00000000; vp[7] = 32'h40C; v1[7] = 32'h5; v2[7] = 32'h6;
        ve[7] = mk(32'h5, 32'h6, 32'd0, 32'h40C, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 3'd0, 1);
        popped = 0;
        out_ready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b1 || sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_valid_%0d out_valid=%0b in_ready=%0b required=1 1", k - 1, out_valid, in_ready);
                end else begin
                    got = sample();
                    want = sb_q.pop_front();
                    popped++;
                    if (got !== want) begin
                        failures++;
                        $display("FAIL b2b_data_%0d got=%h required=%h", k - 1, got, want);
                    end
                end
            end
            if (k < 8) drive(vi[k], vp[k], v1[k], v2[k], ve[k]);
            else in_valid = 1'b0;
        end
        sb_q.delete();
        checks++;
        if (popped != 8) begin
            failures++;
            $display("FAIL b2b_count got=%0d required=8", popped);
        end
    endtask

    task automatic test_async_reset();
        exp_t got;
        @(negedge clk);
        out_ready = 1'b1;
        drive(32'h010000EF, 32'h600, 32'd1, 32'd2,
              mk(32'h600, 32'd2, 32'd16, 32'h600, 1, 5'd0, 5'd1, 1, 0, 0, 0, 1, 0, 3'd0, 0));
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL arst_preload out_valid=%0b required=1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        got = sample();
        checks++;
        if (out_valid !== 1'b0 || got !== '0) begin
            failures++;
            $display("FAIL arst_immediate out_valid=%0b got=%h required out_valid=0 all zero", out_valid, got);
        end
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL arst_release in_ready=%0b out_valid=%0b required=1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_branch();
        test_illegal();
        test_stall();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
